alu3_fitness_sequencer: RTL and testbench

- Sequential evaluation controller for the 10-input / 8-output ALU benchmark datapath (inputs pi0..pi9, outputs po0..po7).
- Sweeps the full input space into two instances at once: a golden reference netlist and an evolved CGP candidate. Accumulates the Hamming distance between their outputs as the candidate's fitness.
- Sits between the CGP evolution loop and the circuit under evaluation. Supports early abort once the error exceeds a caller-supplied limit.

---
 rtl/alu3_fitness_sequencer.sv | 84 ++++++++
 tb/tb_alu3_fitness_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu3_fitness_sequencer.sv
// alu3_fitness_sequencer: sweeps all input vectors into golden and candidate netlists, accumulating masked Hamming error.
module alu3_fitness_sequencer #(
  parameter int NUM_IN = 10,
  parameter int NUM_OUT = 8,
  parameter int SETTLE = 0,
  parameter int ERR_W = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NUM_OUT-1:0] out_mask,
  input  logic [ERR_W-1:0]   err_limit,
  output logic [NUM_IN-1:0]  vec_out,
  input  logic [NUM_OUT-1:0] gold_po,
  input  logic [NUM_OUT-1:0] cand_po,
  output logic               busy,
  output logic               done,
  output logic [ERR_W-1:0]   error_count,
  output logic               perfect,
  output logic               aborted
);
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
  state_t state;
  logic [3:0] settle_cnt;
  logic [NUM_OUT-1:0] mask, diff;
  logic [ERR_W-1:0] limit, e, err_next;
  logic last, over;
  always_comb begin
    diff = (gold_po ^ cand_po) & mask;
    e = '0;
    for (int i = 0; i < NUM_OUT; i++) e = e + ERR_W'(diff[i]);
    err_next = error_count + e;
    over = err_next > limit;
    last = &vec_out;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      settle_cnt <= '0;
      mask <= '0;
      limit <= '0;
      vec_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error_count <= '0;
      perfect <= 1'b0;
      aborted <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mask <= out_mask;
          limit <= err_limit;
          error_count <= '0;
          perfect <= 1'b0;
          aborted <= 1'b0;
          vec_out <= '0;
          settle_cnt <= 4'(SETTLE);
          busy <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        else begin
          error_count <= err_next;
          if (over || last) begin
            // results are registered alongside the done pulse so they are valid with it
            done <= 1'b1;
            busy <= 1'b0;
            perfect <= err_next == '0;
            aborted <= over;
            state <= DONE;
          end else begin
            vec_out <= vec_out + 1'b1;
            settle_cnt <= 4'(SETTLE);
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu3_fitness_sequencer.sv
// tb_alu3_fitness_sequencer: scoreboard bench; drivers push expected results, a done-triggered monitor checks them.
module tb_alu3_fitness_sequencer;
  logic clk = 0, rst_n = 0, start0 = 0, start1 = 0;
  logic [7:0] out_mask = 0;
  logic [13:0] err_limit = 0;
  logic [9:0] vec0, vec1;
  logic [7:0] gold0, cand0, gold1, cand1, p1, p2;
  logic busy0, done0, perfect0, aborted0, busy1, done1, perfect1, aborted1;
  logic [13:0] err0, err1;
  int mode = 0, cyc = 0, pass = 0, total = 0;
  typedef struct {int err; int perfect; int aborted; int vec; int acc; int lat;} exp_t;
  exp_t sb0[$], sb1[$];
  exp_t x0, x1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] f(logic [9:0] v);
    return v[7:0] + {6'b0, v[9:8]};
  endfunction
  assign gold0 = f(vec0);
  assign cand0 = mode == 0 ? gold0 : mode == 1 ? gold0 ^ 8'h80 : mode == 2 ? ~gold0 : gold0 ^ {7'b0, vec0[0]};
  assign gold1 = f(vec1);
  always @(posedge clk) begin
    p1 <= gold1;
    p2 <= p1;
  end
  assign cand1 = p2;
  alu3_fitness_sequencer dut0 (.clk(clk), .rst_n(rst_n), .start(start0), .out_mask(out_mask), .err_limit(err_limit),
    .vec_out(vec0), .gold_po(gold0), .cand_po(cand0), .busy(busy0), .done(done0), .error_count(err0),
    .perfect(perfect0), .aborted(aborted0));
  alu3_fitness_sequencer #(.SETTLE(3)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .out_mask(out_mask),
    .err_limit(err_limit), .vec_out(vec1), .gold_po(gold1), .cand_po(cand1), .busy(busy1), .done(done1),
    .error_count(err1), .perfect(perfect1), .aborted(aborted1));
  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (done0) begin
      chk("dut0 done requested", int'(sb0.size() > 0), 1);
      if (sb0.size() > 0) begin
        x0 = sb0.pop_front();
        chk("dut0 error_count", int'(err0), x0.err);
        chk("dut0 perfect", int'(perfect0), x0.perfect);
        chk("dut0 aborted", int'(aborted0), x0.aborted);
        chk("dut0 vec_out", int'(vec0), x0.vec);
        chk("dut0 latency", cyc - x0.acc, x0.lat);
        chk("dut0 busy at done", int'(busy0), 0);
      end
    end
    if (done1) begin
      chk("dut1 done requested", int'(sb1.size() > 0), 1);
      if (sb1.size() > 0) begin
        x1 = sb1.pop_front();
        chk("dut1 error_count", int'(err1), x1.err);
        chk("dut1 perfect", int'(perfect1), x1.perfect);
        chk("dut1 aborted", int'(aborted1), x1.aborted);
        chk("dut1 vec_out", int'(vec1), x1.vec);
        chk("dut1 latency", cyc - x1.acc, x1.lat);
      end
    end
  end
  task automatic run(int d, int m, logic [7:0] mask, logic [13:0] lim, int e, int ab, int v, int lat);
    exp_t x;
    @(negedge clk);
    mode = m;
    out_mask = mask;
    err_limit = lim;
    if (d == 0) start0 = 1; else start1 = 1;
    @(posedge clk);
    #1;
    start0 = 0;
    start1 = 0;
    x = '{err: e, perfect: int'(e == 0), aborted: ab, vec: v, acc: cyc, lat: lat};
    if (d == 0) sb0.push_back(x); else sb1.push_back(x);
    out_mask = ~mask;
    err_limit = '0;
    for (int i = 0; i < 6000 && (d == 0 ? sb0.size() : sb1.size()) != 0; i++) @(negedge clk);
    if (d == 0) begin
      chk("dut0 timeout", sb0.size(), 0);
      sb0.delete();
    end else begin
      chk("dut1 timeout", sb1.size(), 0);
      sb1.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int acc;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset vec_out", int'(vec0), 0);
    chk("reset busy", int'(busy0), 0);
    chk("reset done", int'(done0), 0);
    chk("reset error_count", int'(err0), 0);
    chk("reset perfect", int'(perfect0), 0);
    chk("reset aborted", int'(aborted0), 0);
    run(0, 0, 8'hFF, 14'h3FFF, 0, 0, 10'h3FF, 1024);
    run(0, 1, 8'hFF, 14'h3FFF, 1024, 0, 10'h3FF, 1024);
    run(0, 2, 8'hFF, 14'h3FFF, 8192, 0, 10'h3FF, 1024);
    run(0, 2, 8'h00, 14'h3FFF, 0, 0, 10'h3FF, 1024);
    run(0, 3, 8'hFF, 14'd5, 6, 1, 11, 12);
    run(0, 3, 8'hFE, 14'd0, 0, 0, 10'h3FF, 1024);
    run(0, 1, 8'hFF, 14'd1023, 1024, 1, 10'h3FF, 1024);
    run(1, 0, 8'hFF, 14'h3FFF, 0, 0, 10'h3FF, 4096);
    @(negedge clk);
    mode = 1;
    out_mask = 8'hFF;
    err_limit = 14'h3FFF;
    start0 = 1;
    @(posedge clk);
    #1;
    start0 = 0;
    acc = cyc;
    while (cyc < acc + 200) @(negedge clk);
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    chk("ignored start vec_out", int'(vec0), 201);
    chk("ignored start error_count", int'(err0), 201);
    chk("ignored start busy", int'(busy0), 1);
    while (cyc < acc + 499) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrun reset busy", int'(busy0), 0);
    chk("midrun reset vec_out", int'(vec0), 0);
    chk("midrun reset error_count", int'(err0), 0);
    chk("midrun reset done", int'(done0), 0);
    repeat (1100) @(negedge clk);
    run(0, 0, 8'hFF, 14'h3FFF, 0, 0, 10'h3FF, 1024);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
